// File: rtl/led_bist_pattern_gen.sv
// Switch-to-LED driver with a built-in pattern self-test.
// WIDTH switches drive WIDTH LEDs through a 2-flop synchroniser. An all-zero
// switch word enters BIST. BIST shows one of four patterns, selected by mode,
// and advances it at a rate divided down from clk.
// Optional build macro LED_BIST_DEBOUNCE_EN adds a debounce filter that holds
// the synchronised switch word until it has been stable for DB_CYCLES clk.
module led_bist_pattern_gen #(
    parameter int WIDTH     = 4,
    parameter int DIV       = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             bist_active
);

    localparam int SW_W = $clog2(2*WIDTH+1);
    localparam int DV_W = $clog2(DIV);

    localparam logic [SW_W-1:0] ST_W     = SW_W'(WIDTH);
    localparam logic [SW_W-1:0] ST_WM1   = SW_W'(WIDTH-1);
    localparam logic [SW_W-1:0] ST_2W    = SW_W'(2*WIDTH);
    localparam logic [SW_W-1:0] ST_BLAST = SW_W'(2*WIDTH-3);
    localparam logic [DV_W-1:0] DV_LAST  = DV_W'(DIV-1);

    typedef enum logic {PASS, BIST} state_t;
    typedef enum logic [1:0] {PAT_FILL, PAT_BOUNCE, PAT_BLINK, PAT_COUNT} pat_t;

    if (WIDTH < 2 || WIDTH > 32 || DIV < 2 || DB_CYCLES < 1) begin : g_bad_param
        $error("led_bist_pattern_gen: parameter out of legal range");
    end

    state_t            state, state_nx;
    pat_t              mode_q;
    logic [WIDTH-1:0]  sync1, sync2, sw_f;
    logic [WIDTH-1:0]  led_nx;
    logic [SW_W-1:0]   step, step_nx, bpos;
    logic [DV_W-1:0]   div_cnt;
    logic              tick;

    // Two-flop synchroniser on the switch pins and a one-clk copy of mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            mode_q <= PAT_FILL;
        end else begin
            sync1  <= sw;
            sync2  <= sync1;
            mode_q <= pat_t'(mode);
        end
    end

`ifdef LED_BIST_DEBOUNCE_EN
    localparam int DBC_W = $clog2(DB_CYCLES+1);
    localparam logic [DBC_W-1:0] DB_FULL = DBC_W'(DB_CYCLES);

    logic [DBC_W-1:0] db_cnt;
    logic [WIDTH-1:0] db_q;

    // db_cnt = clk cycles the current sync2 value has been held (saturating);
    // sync1 != sync2 means sync2 changes on this edge, so the count restarts at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt <= '0;
            db_q   <= '0;
        end else begin
            if (sync1 != sync2)
                db_cnt <= DBC_W'(1);
            else if (db_cnt != DB_FULL)
                db_cnt <= db_cnt + DBC_W'(1);
            if (db_cnt == DB_FULL)
                db_q <= sync2;
        end
    end

    // Filtered switch word seen by the FSM.
    always_comb sw_f = db_q;
`else
    // Filtered switch word seen by the FSM.
    always_comb sw_f = sync2;
`endif

    // Free-running pattern-rate divider.
    always_ff @(posedge clk) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (div_cnt == DV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DV_W'(1);
    end

    assign tick        = (div_cnt == DV_LAST);
    assign bist_active = (state == BIST);

    // State, LED and pattern-step registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PASS;
            led   <= '0;
            step  <= '0;
        end else begin
            state <= state_nx;
            led   <= led_nx;
            step  <= step_nx;
        end
    end

    // Next-state, next LED word and pattern stepping.
    always_comb begin
        state_nx = state;
        led_nx   = led;
        step_nx  = step;
        bpos     = (step < ST_W) ? (ST_WM1 - step) : (step - ST_WM1);
        case (state)
            PASS: begin
                led_nx = sw_f;
                if (sw_f == '0) begin
                    state_nx = BIST;
                    led_nx   = '0;
                    step_nx  = '0;
                end
            end
            BIST: begin
                if (sw_f != '0) begin
                    state_nx = PASS;
                    led_nx   = sw_f;
                end else if (mode != mode_q) begin
                    led_nx  = '0;
                    step_nx = '0;
                end else if (tick) begin
                    step_nx = (step == ST_2W) ? '0 : step + SW_W'(1);
                    case (mode_q)
                        PAT_FILL: begin
                            if (step < ST_W)
                                led_nx = {1'b1, led[WIDTH-1:1]};
                            else if (step < ST_2W)
                                led_nx = {led[WIDTH-2:0], 1'b0};
                            else
                                led_nx = '0;
                        end
                        PAT_BOUNCE: begin
                            led_nx = WIDTH'(1) << bpos;
                            if (step >= ST_BLAST)
                                step_nx = '0;
                        end
                        PAT_BLINK: led_nx = ~led;
                        PAT_COUNT: led_nx = led + WIDTH'(1);
                        default:   led_nx = led;
                    endcase
                end
            end
            default: state_nx = PASS;
        endcase
    end

endmodule

// File: tb/tb_led_bist_pattern_gen.sv
// Self-checking bench for led_bist_pattern_gen (WIDTH=4, DIV=4, DB_CYCLES=8).
// A behavioural model predicts led/bist_active every clk. Patterns come from
// closed-form functions of the tick index. Directed sequences pin literal values.
module tb_led_bist_pattern_gen;

    localparam int W   = 4;
    localparam int DIV = 4;
    localparam int DB  = 8;
`ifdef LED_BIST_DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 3;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw = '0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] led;
    logic         bist_active;

    led_bist_pattern_gen #(.WIDTH(W), .DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode),
        .led(led), .bist_active(bist_active)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // model state
    logic [W-1:0] hist [0:DB+1];
    logic [W-1:0] m_swf, m_led;
    logic [1:0]   m_modeq;
    bit           m_bist, m_adv, m_tick;
    int           cyc, n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT at %0t", nm, $time);
    endtask

    // n-th pattern value (n >= 1) after a pattern restart
    function automatic logic [W-1:0] pat(input logic [1:0] md, input int idx);
        int k, ones, pos;
        case (md)
            2'd0: begin
                k    = (idx - 1) % (2*W + 1);
                ones = (k < W) ? k + 1 : ((k < 2*W) ? 2*W - 1 - k : 0);
                return W'(((1 << ones) - 1) << (W - ones));
            end
            2'd1: begin
                k   = (idx - 1) % (2*W - 2);
                pos = (k < W) ? W - 1 - k : k - W + 1;
                return W'(1 << pos);
            end
            2'd2:    return (idx % 2 == 1) ? {W{1'b1}} : {W{1'b0}};
            default: return W'(idx);
        endcase
    endfunction

    // Reference model, evaluated on each rising edge from the inputs seen there.
    always @(posedge clk) begin
        m_adv = 0;
        if (!rst_n) begin
            for (int i = 0; i <= DB + 1; i++) hist[i] = '0;
            m_swf = '0; m_led = '0; m_bist = 0; m_modeq = 2'd0; cyc = 0; n = 0;
        end else begin
            for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sw;
            cyc++;
            m_tick = (cyc % DIV == 0);
            if (!m_bist) begin
                if (m_swf == '0) begin
                    m_bist = 1; m_led = '0; n = 0;
                end else begin
                    m_led = m_swf;
                end
            end else if (m_swf != '0) begin
                m_bist = 0; m_led = m_swf;
            end else if (mode != m_modeq) begin
                m_led = '0; n = 0;
            end else if (m_tick) begin
                n++;
                m_led = pat(m_modeq, n);
                m_adv = 1;
            end
            m_modeq = mode;
`ifdef LED_BIST_DEBOUNCE_EN
            begin
                bit stable;
                stable = 1;
                for (int i = 3; i <= DB + 1; i++) if (hist[i] !== hist[2]) stable = 0;
                if (stable) m_swf = hist[2];
            end
`else
            m_swf = hist[1];
`endif
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_led", 32'(led), 32'(m_led));
            chk("cyc_bist", 32'(bist_active), 32'(m_bist));
        end
    end

    task automatic expect_tick(input string nm, input logic [W-1:0] exp);
        for (int i = 0; i < 3*DIV; i++) begin
            @(negedge clk);
            if (m_adv) begin
                chk(nm, 32'(led), 32'(exp));
                return;
            end
        end
        timeout(nm);
    endtask

    task automatic skip_tick(input string nm);
        for (int i = 0; i < 3*DIV; i++) begin
            @(negedge clk);
            if (m_adv) return;
        end
        timeout(nm);
    endtask

    task automatic wait_bist(input string nm, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bist_active === 1'b1) return;
        end
        timeout(nm);
    endtask

    logic [W-1:0] fill_exp   [10] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1110,
                                      4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
    logic [W-1:0] bounce_exp [7]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                      4'b0010, 4'b0100, 4'b1000};

    initial begin
        // reset, two clk low
        @(negedge clk);
        chk_en = 1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_bist", 32'(bist_active), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // FILL from reset
        wait_bist("t1_enter", 3);
        chk("t1_bist", 32'(bist_active), 32'h1);
        for (int i = 0; i < 10; i++) expect_tick($sformatf("t1_fill%0d", i), fill_exp[i]);

        // BOUNCE
        mode = 2'd1;
        for (int i = 0; i < 7; i++) expect_tick($sformatf("t2_bounce%0d", i), bounce_exp[i]);

        // exit BIST
        sw = 4'b1010;
        repeat (LAT - 1) @(negedge clk);
        chk("t3_still_bist", 32'(bist_active), 32'h1);
        @(negedge clk);
        chk("t3_exit_led", 32'(led), 32'hA);
        chk("t3_exit_bist", 32'(bist_active), 32'h0);
        repeat (3*DIV) @(negedge clk);
        chk("t3_hold_led", 32'(led), 32'hA);

        // FILL then switch to COUNT
        sw = 4'b0000;
        mode = 2'd0;
        wait_bist("t4_enter", LAT + 2);
        expect_tick("t4_fill0", 4'b1000);
        expect_tick("t4_fill1", 4'b1100);
        mode = 2'd3;
        @(negedge clk);
        chk("t4_restart", 32'(led), 32'h0);
        expect_tick("t4_cnt1", 4'b0001);
        expect_tick("t4_cnt2", 4'b0010);
        expect_tick("t4_cnt3", 4'b0011);
        for (int i = 4; i < 15; i++) skip_tick("t4_cnt_skip");
        expect_tick("t4_cnt15", 4'b1111);
        expect_tick("t4_cnt_wrap", 4'b0000);

        // BLINK, then reset mid-pattern
        mode = 2'd2;
        expect_tick("t5_blink1", 4'b1111);
        expect_tick("t5_blink2", 4'b0000);
        expect_tick("t5_blink3", 4'b1111);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_led", 32'(led), 32'h0);
        chk("t5_rst_bist", 32'(bist_active), 32'h0);
        rst_n = 1'b1;
        wait_bist("t5_reenter", 3);
        expect_tick("t5_first", 4'b1111);

`ifdef LED_BIST_DEBOUNCE_EN
        // short glitch is filtered, long press gets through
        sw = 4'b0001;
        repeat (5) @(negedge clk);
        sw = 4'b0000;
        repeat (20) @(negedge clk);
        chk("t6_glitch_bist", 32'(bist_active), 32'h1);
        sw = 4'b0001;
        repeat (DB + 2) @(negedge clk);
        chk("t6_pre_bist", 32'(bist_active), 32'h1);
        @(negedge clk);
        chk("t6_led", 32'(led), 32'h1);
        chk("t6_bist", 32'(bist_active), 32'h0);
        sw = 4'b0000;
`endif

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0)
                sw = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 39) == 0)
                mode = 2'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
